// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory initiator: FSM state encoding,
// command/size codes and the request legality check.
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size 3 and any access not aligned to its own width never reach the bus.
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Core request/response channel plus the bus command, read and write channels.
// master = the initiator, slave = the core/bus environment around it.
interface mem_initiator_if #(
    parameter int ADDR_BITS = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_cmd;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [ADDR_BITS-1:0] req_addr;
    logic [31:0]          req_wdata;

    logic                 resp_valid;
    logic [31:0]          resp_data;
    logic                 resp_err;

    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_cmd;
    logic [1:0]           mem_size;
    logic                 mem_valid;
    logic                 mem_ready;

    logic                 mem_r_ready;
    logic                 mem_r_valid;
    logic [31:0]          mem_r_data;
    logic                 mem_r_resp;

    logic                 mem_w_valid;
    logic                 mem_w_ready;
    logic [3:0]           mem_w_strb;
    logic [31:0]          mem_w_data;
    logic                 mem_w_resp;

    modport master (
        input  req_valid, req_cmd, req_size, req_signed, req_addr, req_wdata,
        input  mem_ready, mem_r_valid, mem_r_data, mem_r_resp, mem_w_ready, mem_w_resp,
        output req_ready, resp_valid, resp_data, resp_err,
        output mem_addr, mem_cmd, mem_size, mem_valid, mem_r_ready,
        output mem_w_valid, mem_w_strb, mem_w_data
    );

    modport slave (
        output req_valid, req_cmd, req_size, req_signed, req_addr, req_wdata,
        output mem_ready, mem_r_valid, mem_r_data, mem_r_resp, mem_w_ready, mem_w_resp,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  mem_addr, mem_cmd, mem_size, mem_valid, mem_r_ready,
        input  mem_w_valid, mem_w_strb, mem_w_data
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes and lane replication, and load lane
// extraction with zero/sign extension.
module mem_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  strb,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        strb     = 4'b0000;
        st_lanes = '0;
        ld_data  = '0;
        ld_byte  = ld_raw[{addr_lo, 3'b000} +: 8];
        ld_half  = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        case (size)
            SIZE_BYTE: begin
                strb     = 4'b0001 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            end
            SIZE_HALF: begin
                strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {{16{sign_ext & ld_half[15]}}, ld_half};
            end
            SIZE_WORD: begin
                strb     = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_raw;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding load/store initiator bridging a core request port onto a
// split command/read/write bus, with alignment checking and a wait timeout.
//
// state    | meaning
// ST_IDLE  | ready for a core request
// ST_CMD   | command (and write data) presented on the bus
// ST_RDATA | waiting for read data
// ST_RESP  | one-cycle response pulse to the core
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int p_ADDR_BITS = 32,
    parameter int p_DATA_BITS = 32,
    parameter int p_TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_initiator_if.master bus
);

    localparam int TMR_BITS = (p_TIMEOUT < 2) ? 1 : $clog2(p_TIMEOUT + 1);
    localparam logic [TMR_BITS-1:0] TMR_LOAD = TMR_BITS'(p_TIMEOUT);

    state_e                 state_q, state_d;
    logic [p_ADDR_BITS-1:0] addr_q, addr_d;
    logic                   cmd_q, cmd_d;
    logic [1:0]             size_q, size_d;
    logic                   signed_q, signed_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [p_DATA_BITS-1:0] data_q, data_d;
    logic                   err_q, err_d;
    logic [TMR_BITS-1:0]    tmr_q, tmr_d;

    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        timeout_hit;

    mem_lane_align u_align (
        .size     (size_q),
        .sign_ext (signed_q),
        .addr_lo  (addr_q[1:0]),
        .st_data  (wdata_q),
        .ld_raw   (bus.mem_r_data),
        .strb     (lane_strb),
        .st_lanes (lane_wdata),
        .ld_data  (lane_rdata)
    );

    // Down-counter loaded on CMD entry; terminal count 1 marks the last allowed wait cycle.
    assign timeout_hit = (p_TIMEOUT != 0) && (tmr_q == TMR_BITS'(1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        size_d   = size_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        err_d    = err_q;
        tmr_d    = tmr_q;

        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_data   = '0;
        bus.resp_err    = 1'b0;
        bus.mem_valid   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_cmd     = 1'b0;
        bus.mem_size    = '0;
        bus.mem_w_valid = 1'b0;
        bus.mem_w_strb  = '0;
        bus.mem_w_data  = '0;
        bus.mem_r_ready = 1'b0;

        // Reset forces every output low; the register block handles the state.
        if (!rst) begin
            if ((state_q == ST_CMD || state_q == ST_RDATA) && tmr_q != '0)
                tmr_d = tmr_q - 1'b1;

            case (state_q)
                ST_IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        addr_d   = bus.req_addr;
                        cmd_d    = bus.req_cmd;
                        size_d   = bus.req_size;
                        signed_d = bus.req_signed;
                        wdata_d  = bus.req_wdata;
                        data_d   = '0;
                        if (req_illegal(bus.req_size, bus.req_addr[1:0])) begin
                            err_d   = 1'b1;
                            state_d = ST_RESP;
                        end else begin
                            err_d   = 1'b0;
                            tmr_d   = TMR_LOAD;
                            state_d = ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    bus.mem_valid = 1'b1;
                    bus.mem_addr  = {addr_q[p_ADDR_BITS-1:2], 2'b00};
                    bus.mem_cmd   = cmd_q;
                    bus.mem_size  = size_q;
                    if (cmd_q == CMD_WRITE) begin
                        bus.mem_w_valid = 1'b1;
                        bus.mem_w_strb  = lane_strb;
                        bus.mem_w_data  = lane_wdata;
                    end
                    if (cmd_q == CMD_WRITE && bus.mem_ready && bus.mem_w_ready) begin
                        err_d   = bus.mem_w_resp;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else if (timeout_hit) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end else if (cmd_q == CMD_READ && bus.mem_ready) begin
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    bus.mem_r_ready = 1'b1;
                    if (bus.mem_r_valid) begin
                        err_d   = bus.mem_r_resp;
                        data_d  = bus.mem_r_resp ? '0 : lane_rdata;
                        state_d = ST_RESP;
                    end else if (timeout_hit) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = data_q;
                    bus.resp_err   = err_q;
                    state_d        = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cmd_q    <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            err_q    <= err_d;
            tmr_q    <= tmr_d;
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed and randomized transactions against a cycle-count reference model of
// the initiator's alignment, lane steering, extension and timeout behaviour.
module tb_mem_initiator;
    import mem_if_pkg::*;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [3:0]  last_strb;
    logic [31:0] last_wdata;
    logic [31:0] last_maddr;
    logic [31:0] last_data;
    logic        last_err;
    int          last_resp;
    logic        saw_mem_valid;

    always #5 clk = ~clk;

    mem_initiator_if #(.ADDR_BITS(32)) bus ();

    mem_initiator #(
        .p_ADDR_BITS (32),
        .p_DATA_BITS (32),
        .p_TIMEOUT   (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.req_valid   = 1'b0;
        bus.req_cmd     = 1'b0;
        bus.req_size    = 2'd0;
        bus.req_signed  = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_r_valid = 1'b0;
        bus.mem_r_data  = '0;
        bus.mem_r_resp  = 1'b0;
        bus.mem_w_ready = 1'b0;
        bus.mem_w_resp  = 1'b0;
    endtask

    // a: cycles mem_ready stays low; a2: cycles mem_w_ready stays low;
    // b: extra cycles before read data after the command handshake.
    task automatic run_txn(input logic cmd, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic bresp,
                           input int a, input int a2, input int b);
        int          nb, lo, done, resp, cmd_last;
        logic        illegal, exp_err, in_rd;
        logic [3:0]  exp_strb;
        logic [31:0] exp_lanes, exp_data, ext;
        logic [63:0] v;

        lo = int'(addr[1:0]);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        illegal = (size == 2'd3) || ((lo % nb) != 0);
        for (int i = 0; i < 4; i++) begin
            exp_strb[i] = (i >= lo) && (i < lo + nb);
            exp_lanes[8*i +: 8] = wdata[8*(i % nb) +: 8];
        end
        v = 64'(rdata >> (8 * lo));
        v = v & ((64'd1 << (8 * nb)) - 64'd1);
        if (sgn && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
        ext = v[31:0];

        if (illegal) begin
            resp = 1; cmd_last = 0; exp_err = 1'b1; exp_data = '0;
        end else if (cmd == CMD_WRITE) begin
            done = ((a > a2) ? a : a2) + 1;
            if (done <= T) begin resp = done + 1; exp_err = bresp; end
            else begin resp = T + 1; exp_err = 1'b1; end
            cmd_last = resp - 1; exp_data = '0;
        end else begin
            done = a + b + 2;
            cmd_last = (a + 1 < T) ? a + 1 : T;
            if (done <= T) begin
                resp = done + 1; exp_err = bresp; exp_data = bresp ? 32'd0 : ext;
            end else begin
                resp = T + 1; exp_err = 1'b1; exp_data = '0;
            end
        end

        saw_mem_valid = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_cmd    = cmd;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        #1;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        bus.req_wdata = $urandom();

        for (int k = 1; k <= resp; k++) begin
            in_rd = !illegal && (cmd == CMD_READ) && (k > cmd_last) && (k < resp);
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            chk("resp_valid", 32'(bus.resp_valid), 32'(k == resp));
            chk("mem_valid", 32'(bus.mem_valid), 32'(k <= cmd_last));
            chk("mem_w_valid", 32'(bus.mem_w_valid), 32'((cmd == CMD_WRITE) && (k <= cmd_last)));
            chk("mem_r_ready", 32'(bus.mem_r_ready), 32'(in_rd));
            if (bus.mem_valid) saw_mem_valid = 1'b1;
            if (k <= cmd_last) begin
                chk("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
                chk("mem_cmd", 32'(bus.mem_cmd), 32'(cmd));
                chk("mem_size", 32'(bus.mem_size), 32'(size));
                last_maddr = bus.mem_addr;
                if (cmd == CMD_WRITE) begin
                    chk("mem_w_strb", 32'(bus.mem_w_strb), 32'(exp_strb));
                    chk("mem_w_data", bus.mem_w_data, exp_lanes);
                    last_strb  = bus.mem_w_strb;
                    last_wdata = bus.mem_w_data;
                end
            end
            if (k == resp) begin
                chk("resp_data", bus.resp_data, exp_data);
                chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
                last_data = bus.resp_data;
                last_err  = bus.resp_err;
                if (bus.resp_valid) last_resp = k;
            end
            bus.mem_ready   = (k > a);
            bus.mem_w_ready = (cmd == CMD_WRITE) && (k > a2);
            bus.mem_w_resp  = bresp;
            bus.mem_r_valid = (cmd == CMD_READ) && (k >= a + b + 2);
            bus.mem_r_data  = ((cmd == CMD_READ) && (k >= a + b + 2)) ? rdata : $urandom();
            bus.mem_r_resp  = bresp;
            @(posedge clk); @(negedge clk);
        end
        chk("req_ready_after", 32'(bus.req_ready), 32'd1);
        chk("resp_valid_after", 32'(bus.resp_valid), 32'd0);
        chk("mem_valid_after", 32'(bus.mem_valid), 32'd0);
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_w_valid", 32'(bus.mem_w_valid), 32'd0);
        chk("rst_r_ready", 32'(bus.mem_r_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_strb", 32'(bus.mem_w_strb), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        run_txn(CMD_WRITE, SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0, 0);
        chk("w_word_strb", 32'(last_strb), 32'hF);
        chk("w_word_data", last_wdata, 32'hDEADBEEF);
        chk("w_word_addr", last_maddr, 32'h100);
        chk("w_word_lat", 32'(last_resp), 32'd2);
        chk("w_word_err", 32'(last_err), 32'd0);

        run_txn(CMD_READ, SIZE_BYTE, 1'b1, 32'h103, 32'h0, 32'h80123456, 1'b0, 0, 0, 0);
        chk("ld_sbyte", last_data, 32'hFFFFFF80);
        chk("ld_sbyte_lat", 32'(last_resp), 32'd3);
        run_txn(CMD_READ, SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h80123456, 1'b0, 0, 0, 0);
        chk("ld_ubyte", last_data, 32'h00000080);

        run_txn(CMD_WRITE, SIZE_HALF, 1'b0, 32'h102, 32'h1234, 32'h0, 1'b0, 0, 0, 0);
        chk("st_half_strb", 32'(last_strb), 32'hC);
        chk("st_half_data", last_wdata, 32'h12341234);

        run_txn(CMD_READ, SIZE_WORD, 1'b0, 32'h101, 32'h0, 32'h55AA55AA, 1'b0, 0, 0, 0);
        chk("misal_lat", 32'(last_resp), 32'd1);
        chk("misal_err", 32'(last_err), 32'd1);
        chk("misal_data", last_data, 32'd0);
        chk("misal_no_bus", 32'(saw_mem_valid), 32'd0);

        run_txn(CMD_READ, SIZE_WORD, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0, 0, 0, 50);
        chk("tmo_lat", 32'(last_resp), 32'd5);
        chk("tmo_err", 32'(last_err), 32'd1);

        run_txn(CMD_WRITE, SIZE_HALF, 1'b0, 32'h206, 32'hABCD, 32'h0, 1'b0, 3, 0, 0);
        chk("stall_lat", 32'(last_resp), 32'd5);
        chk("stall_err", 32'(last_err), 32'd0);

        // Reset while waiting for read data.
        bus.req_valid = 1'b1;
        bus.req_cmd   = CMD_READ;
        bus.req_size  = SIZE_WORD;
        bus.req_addr  = 32'h200;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_rdata", 32'(bus.mem_r_ready), 32'd1);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_r_ready", 32'(bus.mem_r_ready), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_idle", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("mid_rst_no_resp2", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_idle2", 32'(bus.req_ready), 32'd1);

        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom(), $urandom(), $urandom(), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
